prog_updown_counter: RTL

- Parametrised successor of the team's bus-programmable up/down counter.
- Host programs preload (PLR), lower limit (LLR), upper limit (ULR), cycle count (CCR) and a mode register through a chip-select/read/write port.
- A start edge runs CCR complete count cycles in one of three modes (bounce, up-wrap, down-wrap), then raises end-of-count.
- Adds over the previous generation: width parameters, a registered read-back bus, status and remaining-cycle readback, abort, and strict range checking.

---
 rtl/prog_updown_counter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/prog_updown_counter.sv
// prog_updown_counter
//   Bus-programmable up/down counter. A host loads preload (PLR), upper and
//   lower limits (ULR/LLR), cycle count (CCR) and MODE over a chip-select
//   port. A rising edge on start_in runs CCR complete count cycles in bounce,
//   up-wrap or down-wrap mode, then raises ec_out.
// Ports:
//   clk_in, reset_in        clock, asynchronous active-low reset
//   ncs_in, nwr_in, nrd_in  active-low chip select / write / read strobes
//   addr_in, din, dout      register address, write data, registered read data
//   start_in                run request, rising-edge sensitive
//   count_out, dir_out      current count, direction of the next step (1 = up)
//   busy_out, err_out       run in progress, bad configuration at last start
//   ec_out                  all cycles completed
module prog_updown_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CCR_WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             ncs_in,
  input  logic             nwr_in,
  input  logic             nrd_in,
  input  logic [2:0]       addr_in,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             start_in,
  output logic [WIDTH-1:0] count_out,
  output logic             dir_out,
  output logic             busy_out,
  output logic             err_out,
  output logic             ec_out
);

  typedef enum logic {S_IDLE, S_COUNT} state_e;
  typedef enum logic [1:0] {M_BOUNCE = 2'b00, M_UP = 2'b01, M_DOWN = 2'b10, M_RSVD = 2'b11} mode_e;

  state_e               state_q;
  mode_e                mode_q;
  logic [WIDTH-1:0]     plr_q, ulr_q, llr_q, cnt_q, dout_q;
  logic [CCR_WIDTH-1:0] ccr_q, rem_q;
  logic [WIDTH:0]       step_q;
  logic                 dir_q, err_q, ec_q, start_q;

  logic                 wr_en, rd_en, start_ev, abort, cfg_bad;
  logic                 eff_up, dir_d, cyc_done;
  logic [WIDTH-1:0]     cnt_d, span, rd_val;
  logic [WIDTH:0]       step_d, cyc_len;
  logic [1:0]           mode_bits;
  logic [3:0]           status;

  assign wr_en     = !ncs_in && !nwr_in;
  assign rd_en     = !ncs_in && !nrd_in && nwr_in;
  assign start_ev  = start_in && !start_q;
  assign abort     = wr_en && (addr_in == 3'd4) && din[2];
  assign cfg_bad   = (mode_q == M_RSVD) ||
                     !((llr_q < ulr_q) && (llr_q <= plr_q) && (plr_q <= ulr_q));
  assign mode_bits = mode_q;
  assign status    = {busy_out, dir_q, ec_q, err_q};

  // Next count/direction for one step in the current mode.
  always_comb begin
    eff_up = dir_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    unique case (mode_q)
      M_BOUNCE: begin
        // Limits force the turn, so a run loaded at ULR starts downward.
        eff_up = (cnt_q == ulr_q) ? 1'b0 : (cnt_q == llr_q) ? 1'b1 : dir_q;
        cnt_d  = eff_up ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
        dir_d  = (cnt_d == ulr_q) ? 1'b0 : (cnt_d == llr_q) ? 1'b1 : eff_up;
      end
      M_UP: begin
        cnt_d = (cnt_q == ulr_q) ? llr_q : cnt_q + WIDTH'(1);
        dir_d = 1'b1;
      end
      M_DOWN: begin
        cnt_d = (cnt_q == llr_q) ? ulr_q : cnt_q - WIDTH'(1);
        dir_d = 1'b0;
      end
      default: begin
        cnt_d = cnt_q;
        dir_d = dir_q;
      end
    endcase
  end

  // Cycle completion is tracked by step count: a bounce cycle passes PLR
  // mid-cycle, so matching the count against PLR alone is not enough.
  assign span     = ulr_q - llr_q;
  assign cyc_len  = (mode_q == M_BOUNCE) ? {span, 1'b0} : {1'b0, span} + (WIDTH+1)'(1);
  assign step_d   = step_q + (WIDTH+1)'(1);
  assign cyc_done = (step_d == cyc_len);

  always_comb begin
    rd_val = '0;
    unique case (addr_in)
      3'd0: rd_val = plr_q;
      3'd1: rd_val = ulr_q;
      3'd2: rd_val = llr_q;
      3'd3: rd_val = WIDTH'(ccr_q);
      3'd4: rd_val = WIDTH'(mode_bits);
      3'd5: rd_val = WIDTH'(status);
      3'd6: rd_val = WIDTH'(rem_q);
      3'd7: rd_val = cnt_q;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= S_IDLE;
      mode_q  <= M_BOUNCE;
      plr_q   <= '0;
      ulr_q   <= '1;
      llr_q   <= '0;
      ccr_q   <= '0;
      rem_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b1;
      err_q   <= 1'b0;
      ec_q    <= 1'b0;
      dout_q  <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= start_in;

      if (wr_en && state_q == S_IDLE) begin
        unique case (addr_in)
          3'd0: plr_q  <= din;
          3'd1: ulr_q  <= din;
          3'd2: llr_q  <= din;
          3'd3: ccr_q  <= din[CCR_WIDTH-1:0];
          3'd4: mode_q <= mode_e'(din[1:0]);
          default: ;
        endcase
      end

      if (rd_en) dout_q <= rd_val;

      unique case (state_q)
        S_IDLE: begin
          if (start_ev) begin
            if (cfg_bad) begin
              err_q <= 1'b1;
              ec_q  <= 1'b0;
            end else if (ccr_q == '0) begin
              err_q <= 1'b0;
              ec_q  <= 1'b1;
            end else begin
              err_q   <= 1'b0;
              ec_q    <= 1'b0;
              cnt_q   <= plr_q;
              rem_q   <= ccr_q;
              step_q  <= '0;
              dir_q   <= (mode_q != M_DOWN);
              state_q <= S_COUNT;
            end
          end
        end
        S_COUNT: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            if (cyc_done) begin
              step_q <= '0;
              rem_q  <= rem_q - CCR_WIDTH'(1);
              if (rem_q == CCR_WIDTH'(1)) begin
                ec_q    <= 1'b1;
                state_q <= S_IDLE;
              end
            end else begin
              step_q <= step_d;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dout      = dout_q;
  assign count_out = cnt_q;
  assign dir_out   = dir_q;
  assign busy_out  = (state_q == S_COUNT);
  assign err_out   = err_q;
  assign ec_out    = ec_q;

endmodule
